// File: rtl/lcd_pio_in_edge.sv
// lcd_pio_in_edge
//   Avalon-MM slave input port with edge capture and a level interrupt.
//   Samples asynchronous status lines from the LCD/touch/I2C peripheral,
//   latches the selected edge type into write-1-to-clear capture bits and
//   raises irq while any unmasked capture bit is set.
//
// Register map (word address):
//   0  data      read-only, synchronized in_port
//   1  irq_mask  read/write
//   2  reserved  reads 0, writes ignored
//   3  edge_cap  write-1-to-clear
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   address     register word address
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   readdata    registered read data, one cycle after the address
//   in_port     asynchronous external inputs
//   irq         level interrupt, active-high
module lcd_pio_in_edge #(
    parameter int WIDTH       = 1,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // Terminal count must be representable: SYNC_STAGES+1 is 4 when three
    // stages are used, which needs one more bit than the two-stage case.
    localparam int ARM_W = (SYNC_STAGES >= 3) ? 3 : 2;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] rd_mux;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;
    logic             wr;
    logic             mask_wr;

    assign sync_q   = sync_chain[SYNC_STAGES-1];
    assign data_reg = sync_q;

    // Synchronizer chain and previous-sample register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_chain[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= sync_chain[i-1];
            end
            prev_q <= sync_q;
        end
    end

    // Arm counter: holds off detection until the chain and prev_q hold real
    // post-reset samples, so lines already high at reset give no edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            arm_cnt <= '0;
        end else if (arm_cnt != ARM_LAST) begin
            arm_cnt <= arm_cnt + 1'b1;
        end
    end

    assign armed = (arm_cnt == ARM_LAST);

    always_comb begin
        edge_raw = '0;
        case (EDGE_TYPE)
            0:       edge_raw = sync_q & ~prev_q;
            1:       edge_raw = ~sync_q & prev_q;
            default: edge_raw = sync_q ^ prev_q;
        endcase
        edge_det = armed ? edge_raw : '0;
    end

    assign wr      = chipselect & ~write_n;
    assign mask_wr = wr && (address == 2'd1);
    assign clr     = (wr && (address == 2'd3)) ? writedata : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = data_reg;
            2'd1:    rd_mux = irq_mask;
            2'd3:    rd_mux = edge_cap;
            default: rd_mux = '0;
        endcase
    end

    // Read data and irq are taken from pre-write state; a new edge wins
    // over a simultaneous clear of the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask <= '0;
            edge_cap <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (mask_wr) begin
                irq_mask <= writedata;
            end
            edge_cap <= (edge_cap & ~clr) | edge_det;
            readdata <= rd_mux;
            irq      <= |(edge_cap & irq_mask);
        end
    end

endmodule

// File: tb/tb_lcd_pio_in_edge.sv
// tb_lcd_pio_in_edge
//   Drives three 4-bit instances (rising, falling, any edge) from shared
//   inputs and compares readdata/irq every cycle against a history-based
//   reference model, with directed scenarios followed by random traffic.
module tb_lcd_pio_in_edge;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] address;
    logic       chipselect;
    logic       write_n;
    logic [3:0] writedata;
    logic [3:0] in_port;
    logic [3:0] rd_rise, rd_fall, rd_any;
    logic       irq_rise, irq_fall, irq_any;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lcd_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(SYNC)) dut_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_rise),
        .in_port(in_port), .irq(irq_rise)
    );

    lcd_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(1), .SYNC_STAGES(SYNC)) dut_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_fall),
        .in_port(in_port), .irq(irq_fall)
    );

    lcd_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(SYNC)) dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_any),
        .in_port(in_port), .irq(irq_any)
    );

    // Reference model: hist holds the in_port samples taken at the last
    // SYNC+1 clock edges (oldest first); nr counts edges since reset.
    logic [3:0] hist [$];
    int         nr;
    logic [3:0] m_mask;
    logic [3:0] m_cap [3];
    logic [3:0] m_rd  [3];
    logic       m_irq [3];
    bit         model_valid = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] edges(input int et, input logic [3:0] cur, input logic [3:0] prv);
        case (et)
            0:       return cur & ~prv;
            1:       return ~cur & prv;
            default: return cur ^ prv;
        endcase
    endfunction

    task automatic model_step();
        logic [3:0] cur, prv, clr, ed;
        bit wr;
        if (reset) begin
            foreach (hist[k]) hist[k] = '0;
            nr     = 0;
            m_mask = '0;
            for (int e = 0; e < 3; e++) begin
                m_cap[e] = '0;
                m_rd[e]  = '0;
                m_irq[e] = 1'b0;
            end
            model_valid = 1;
        end else begin
            cur = hist[hist.size()-SYNC];
            prv = hist[hist.size()-SYNC-1];
            wr  = chipselect && !write_n;
            clr = (wr && address == 2'd3) ? writedata : 4'h0;
            for (int e = 0; e < 3; e++) begin
                ed = (nr >= SYNC + 1) ? edges(e, cur, prv) : 4'h0;
                case (address)
                    2'd0:    m_rd[e] = cur;
                    2'd1:    m_rd[e] = m_mask;
                    2'd2:    m_rd[e] = 4'h0;
                    default: m_rd[e] = m_cap[e];
                endcase
                m_irq[e] = |(m_cap[e] & m_mask);
                m_cap[e] = (m_cap[e] & ~clr) | ed;
            end
            if (wr && address == 2'd1) m_mask = writedata;
            hist.push_back(in_port);
            void'(hist.pop_front());
            if (nr < SYNC + 1) nr++;
        end
    endtask

    task automatic step(input logic r, input logic c, input logic w_n,
                        input logic [1:0] a, input logic [3:0] d, input logic [3:0] i);
        reset      = r;
        chipselect = c;
        write_n    = w_n;
        address    = a;
        writedata  = d;
        in_port    = i;
        @(posedge clk);
        model_step();
        #1;
        if (model_valid) begin
            check("rd_rise",  rd_rise,  m_rd[0]);
            check("rd_fall",  rd_fall,  m_rd[1]);
            check("rd_any",   rd_any,   m_rd[2]);
            check("irq_rise", irq_rise, m_irq[0]);
            check("irq_fall", irq_fall, m_irq[1]);
            check("irq_any",  irq_any,  m_irq[2]);
        end
    endtask

    // Shorthands: idle read of an address, and a register write.
    task automatic rd(input logic [1:0] a, input logic [3:0] i);
        step(1'b0, 1'b1, 1'b1, a, 4'h0, i);
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d, input logic [3:0] i);
        step(1'b0, 1'b1, 1'b0, a, d, i);
    endtask

    initial begin
        logic [3:0] cur_in;
        int hold;

        for (int k = 0; k < SYNC + 1; k++) hist.push_back(4'h0);

        // Inputs high through reset and afterwards: no false edges.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 2'd3, 4'h0, 4'hF);
        for (int k = 0; k < 10; k++) rd(2'd3, 4'hF);
        check("init_cap_rise", rd_rise, 4'h0);
        check("init_cap_any",  rd_any,  4'h0);
        check("init_irq_rise", irq_rise, 1'b0);
        rd(2'd0, 4'hF);
        check("init_data", rd_rise, 4'hF);

        // Rising edge timing with mask enabled.
        wr(2'd1, 4'hF, 4'hF);
        for (int k = 0; k < 6; k++) rd(2'd3, 4'h0);
        wr(2'd3, 4'hF, 4'h0);
        rd(2'd3, 4'h0);
        rd(2'd3, 4'hF);             // input rises before this edge
        rd(2'd3, 4'hF);
        rd(2'd3, 4'hF);             // edge_cap sets here
        check("rise_irq_t3", irq_rise, 1'b0);
        rd(2'd3, 4'hF);
        check("rise_cap_t4", rd_rise, 4'hF);
        check("rise_irq_t4", irq_rise, 1'b1);

        // Clear while input stays high: no re-capture.
        wr(2'd3, 4'hF, 4'hF);
        rd(2'd3, 4'hF);
        check("clr_cap", rd_rise, 4'h0);
        check("clr_irq", irq_rise, 1'b0);
        for (int k = 0; k < 4; k++) rd(2'd3, 4'hF);
        check("clr_no_recap", rd_rise, 4'h0);

        // Clear in the same cycle a new rising edge is detected.
        for (int k = 0; k < 4; k++) rd(2'd3, 4'h0);
        wr(2'd3, 4'hF, 4'h0);
        rd(2'd3, 4'hF);
        rd(2'd3, 4'hF);
        wr(2'd3, 4'hF, 4'hF);       // detection and clear coincide
        rd(2'd3, 4'hF);
        check("setwins_cap", rd_rise, 4'hF);
        check("setwins_irq", irq_rise, 1'b1);

        // Any-edge, partial mask.
        for (int k = 0; k < 4; k++) rd(2'd3, 4'h0);
        wr(2'd3, 4'hF, 4'h0);
        wr(2'd1, 4'b0101, 4'h0);
        rd(2'd3, 4'b0110);
        for (int k = 0; k < 4; k++) rd(2'd3, 4'b0110);
        check("any_cap", rd_any, 4'b0110);
        check("any_irq", irq_any, 1'b1);
        wr(2'd1, 4'b0001, 4'b0110);
        rd(2'd3, 4'b0110);
        check("any_masked_irq", irq_any, 1'b0);
        check("any_masked_cap", rd_any, 4'b0110);

        // Mid-operation reset with everything set.
        wr(2'd1, 4'hF, 4'b0110);
        for (int k = 0; k < 4; k++) rd(2'd3, 4'b1001);
        check("pre_rst_cap", rd_any, 4'hF);
        step(1'b1, 1'b0, 1'b1, 2'd3, 4'h0, 4'hF);
        check("rst_rd",  rd_any,  4'h0);
        check("rst_irq", irq_any, 1'b0);
        rd(2'd1, 4'hF);
        check("rst_mask", rd_any, 4'h0);
        wr(2'd0, 4'h5, 4'hF);
        wr(2'd2, 4'hA, 4'hF);
        rd(2'd2, 4'hF);
        check("rsvd_read", rd_any, 4'h0);
        rd(2'd3, 4'hF);
        check("rst_no_cap", rd_any, 4'h0);

        // Random traffic.
        cur_in = 4'h0;
        hold   = 0;
        for (int k = 0; k < 600; k++) begin
            if (hold == 0) begin
                cur_in = 4'($urandom);
                hold   = $urandom_range(1, 5);
            end
            hold--;
            step($urandom_range(0, 79) == 0, 1'($urandom), $urandom_range(0, 2) != 0,
                 2'($urandom), 4'($urandom), cur_in);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
